// File: rtl/data_memory_ctrl.sv
// Data memory for the approx CPU: word array, CPU port with byte enables, loader port, post-reset clear sweep.
// Latency: CPU reads return one cycle after acceptance. Loader and CPU writes land on the accepting edge.
// Backpressure: cpu_ready is low during the clear sweep and whenever ld_we is high, because the loader has priority.
//
// Ports:
//   clk, reset (async, active-high)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_be  -> CPU request; accepted when cpu_req && cpu_ready
//   cpu_ready, cpu_rvalid, cpu_rdata, cpu_err -> handshake, read return (held), out-of-range pulse
//   ld_we/ld_addr/ld_data                     -> full-word loader writes; out-of-range dropped silently
//   init_busy                                 -> high while the clear sweep runs
// Optional feature: define APPROX_STORE_EN to zero the APPROX_BITS LSBs of every CPU store.
module data_memory_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 100,
  parameter int ADDR_W      = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ready,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_err,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                init_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range checks use the full address width plus a guard bit so no upper bit is ever dropped.
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef APPROX_STORE_EN
  localparam int ZERO_BITS = APPROX_BITS;
`else
  localparam int ZERO_BITS = 0;
`endif
  // With ZERO_BITS = 0 this mask is all ones, so exact stores need no separate path.
  localparam logic [DATA_W-1:0] KEEP_MASK =
    ~((DATA_W'(1) << ZERO_BITS) - DATA_W'(1));

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
  logic               cpu_rvalid_q, cpu_rvalid_d;
  logic               cpu_err_q, cpu_err_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  logic               cpu_in_range;
  logic               ld_in_range;
  logic [IDX_W-1:0]   cpu_idx;
  logic [IDX_W-1:0]   ld_idx;
  logic [DATA_W-1:0]  cpu_old;
  logic [DATA_W-1:0]  cpu_wdata_eff;
  logic [DATA_W-1:0]  cpu_merged;

  assign cpu_in_range  = ({1'b0, cpu_addr} < DEPTH_A);
  assign ld_in_range   = ({1'b0, ld_addr} < DEPTH_A);
  assign cpu_idx       = cpu_addr[IDX_W-1:0];
  assign ld_idx        = ld_addr[IDX_W-1:0];
  // Only consumed when cpu_in_range is true, so the truncated index is safe here.
  assign cpu_old       = mem_q[cpu_idx];
  assign cpu_wdata_eff = cpu_wdata & KEEP_MASK;

  // Read-modify-write merge: disabled bytes keep the stored value.
  always_comb begin
    cpu_merged = cpu_old;
    for (int i = 0; i < BE_W; i++) begin
      if (cpu_be[i]) begin
        cpu_merged[8*i +: 8] = cpu_wdata_eff[8*i +: 8];
      end
    end
  end

  assign cpu_ready = (state_q == ST_RUN) && !ld_we;
  assign init_busy = (state_q == ST_INIT);

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = init_cnt_q;
    mem_wdata    = '0;
    cpu_rvalid_d = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;

    case (state_q)
      ST_INIT: begin
        // Sweep owns the write port; loader and CPU are both locked out.
        mem_we    = 1'b1;
        mem_waddr = init_cnt_q;
        if (init_cnt_q == LAST_IDX) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (ld_we) begin
          if (ld_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = ld_idx;
            mem_wdata = ld_data;
          end
        end else if (cpu_req) begin
          cpu_err_d = !cpu_in_range;
          if (cpu_we) begin
            if (cpu_in_range) begin
              mem_we    = 1'b1;
              mem_waddr = cpu_idx;
              mem_wdata = cpu_merged;
            end
          end else begin
            cpu_rvalid_d = 1'b1;
            cpu_rdata_d  = cpu_in_range ? cpu_old : '0;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Storage is not reset; the sweep clears it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = cpu_rdata_q;

endmodule
